// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus bundle shared by the OAM DMA arbiter and its environment.
// The arbiter takes the slave view; the CPU/memory side takes the master view.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_nread;
  logic        cpu_nwrite;
  logic        cpu_nsel;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_nread;
  logic        mem_nwrite;
  logic        mem_nsel;
  logic        dma_active;
  logic [7:0]  dma_reg;

  modport slave (
    input  cpu_address, cpu_wdata, cpu_nread, cpu_nwrite, cpu_nsel, mem_rdata,
    output cpu_rdata, mem_address, mem_wdata, mem_nread, mem_nwrite, mem_nsel,
    output dma_active, dma_reg
  );

  modport master (
    output cpu_address, cpu_wdata, cpu_nread, cpu_nwrite, cpu_nsel, mem_rdata,
    input  cpu_rdata, mem_address, mem_wdata, mem_nread, mem_nwrite, mem_nsel,
    input  dma_active, dma_reg
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU memory bus between CPU passthrough and a 160-byte OAM DMA copy;
// CPU HRAM accesses pre-empt the copy, the DMA register lives inside this block.
module oam_dma_arbiter (
  input  logic             clock,
  input  logic             reset,
  oam_dma_arbiter_if.slave bus
);

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [7:0]  DMA_LEN      = 8'd160;
  localparam logic [7:0]  LAST_IDX     = DMA_LEN - 8'd1;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic [7:0]  idx_r, idx_nx_s;
  logic [7:0]  latch_r, latch_nx_s;
  logic [7:0]  dma_reg_r, dma_reg_nx_s;

  logic        cpu_access_s;
  logic        cpu_read_s;
  logic        cpu_write_s;
  logic        reg_hit_s;
  logic        hram_hit_s;
  logic        reg_read_s;
  logic        reg_write_s;
  logic        reg_access_s;
  logic        hram_access_s;
  logic        blocked_read_s;

  logic [15:0] mem_address_s;
  logic [7:0]  mem_wdata_s;
  logic        mem_nread_s;
  logic        mem_nwrite_s;
  logic        mem_nsel_s;
  logic [7:0]  cpu_rdata_s;

  // Both strobes low counts as a read, so a write needs nread high.
  assign cpu_access_s   = !bus.cpu_nsel && (!bus.cpu_nread || !bus.cpu_nwrite);
  assign cpu_read_s     = cpu_access_s && !bus.cpu_nread;
  assign cpu_write_s    = cpu_access_s && bus.cpu_nread && !bus.cpu_nwrite;
  assign reg_hit_s      = (bus.cpu_address == DMA_REG_ADDR);
  assign hram_hit_s     = (bus.cpu_address >= HRAM_LO) && (bus.cpu_address <= HRAM_HI);
  assign reg_read_s     = cpu_read_s && reg_hit_s;
  assign reg_write_s    = cpu_write_s && reg_hit_s;
  assign reg_access_s   = cpu_access_s && reg_hit_s;
  assign hram_access_s  = cpu_access_s && hram_hit_s;
  assign blocked_read_s = cpu_read_s && !reg_hit_s && !hram_hit_s && (state_r != ST_IDLE);

  // State, index, byte latch and DMA register storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= 8'd0;
      latch_r   <= 8'h00;
      dma_reg_r <= 8'hFF;
    end else begin
      state_r   <= state_nx_s;
      idx_r     <= idx_nx_s;
      latch_r   <= latch_nx_s;
      dma_reg_r <= dma_reg_nx_s;
    end
  end

  // Next-state logic; a register write restarts the copy from any state.
  always_comb begin
    state_nx_s   = state_r;
    idx_nx_s     = idx_r;
    latch_nx_s   = latch_r;
    dma_reg_nx_s = dma_reg_r;
    if (reg_write_s) begin
      dma_reg_nx_s = bus.cpu_wdata;
      state_nx_s   = ST_START;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_START: begin
          idx_nx_s   = 8'd0;
          state_nx_s = ST_READ;
        end
        ST_READ: begin
          if (hram_access_s) begin
            state_nx_s = ST_READ;
          end else begin
            latch_nx_s = bus.mem_rdata;
            state_nx_s = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (hram_access_s) begin
            state_nx_s = ST_WRITE;
          end else if (idx_r == LAST_IDX) begin
            state_nx_s = ST_IDLE;
          end else begin
            idx_nx_s   = idx_r + 8'd1;
            state_nx_s = ST_READ;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Bus ownership: CPU passthrough by default, DMA drives READ/WRITE unless HRAM pre-empts.
  always_comb begin
    mem_address_s = bus.cpu_address;
    mem_wdata_s   = bus.cpu_wdata;
    mem_nread_s   = bus.cpu_nread;
    mem_nwrite_s  = bus.cpu_nwrite;
    mem_nsel_s    = bus.cpu_nsel;
    case (state_r)
      ST_IDLE: begin
        if (reg_access_s) begin
          mem_nsel_s   = 1'b1;
          mem_nread_s  = 1'b1;
          mem_nwrite_s = 1'b1;
        end else begin
          mem_nsel_s = bus.cpu_nsel;
        end
      end
      ST_START: begin
        if (hram_access_s) begin
          mem_nsel_s = bus.cpu_nsel;
        end else begin
          mem_nsel_s   = 1'b1;
          mem_nread_s  = 1'b1;
          mem_nwrite_s = 1'b1;
        end
      end
      ST_READ: begin
        if (hram_access_s) begin
          mem_nsel_s = bus.cpu_nsel;
        end else begin
          mem_address_s = {dma_reg_r, idx_r};
          mem_nsel_s    = 1'b0;
          mem_nread_s   = 1'b0;
          mem_nwrite_s  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (hram_access_s) begin
          mem_nsel_s = bus.cpu_nsel;
        end else begin
          mem_address_s = OAM_BASE + {8'h00, idx_r};
          mem_wdata_s   = latch_r;
          mem_nsel_s    = 1'b0;
          mem_nread_s   = 1'b1;
          mem_nwrite_s  = 1'b0;
        end
      end
      default: begin
        mem_nsel_s   = 1'b1;
        mem_nread_s  = 1'b1;
        mem_nwrite_s = 1'b1;
      end
    endcase
  end

  // CPU read data: register, blocked (open bus 0xFF) or memory.
  always_comb begin
    cpu_rdata_s = bus.mem_rdata;
    if (reg_read_s) begin
      cpu_rdata_s = dma_reg_r;
    end else if (blocked_read_s) begin
      cpu_rdata_s = 8'hFF;
    end else begin
      cpu_rdata_s = bus.mem_rdata;
    end
  end

  assign bus.mem_address = mem_address_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.mem_nread   = mem_nread_s;
  assign bus.mem_nwrite  = mem_nwrite_s;
  assign bus.mem_nsel    = mem_nsel_s;
  assign bus.cpu_rdata   = cpu_rdata_s;
  assign bus.dma_active  = (state_r != ST_IDLE);
  assign bus.dma_reg     = dma_reg_r;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: stimulus pushes expected bus cycles and CPU read
// data, a negedge monitor pops and compares; a 64 KiB array models the memory.
module tb_oam_dma_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } bus_op_t;

  logic clock;
  logic reset;
  oam_dma_arbiter_if bus ();

  oam_dma_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:65535];
  bus_op_t    cpu_q [$];
  bus_op_t    dma_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] exp_src [0:159];
  logic [7:0] model_reg;
  int         checks;
  int         errors;
  int         act_cycles;
  int         base_cycles;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.mem_rdata = mem[bus.mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: initial contents, then writes on the bus at each rising edge.
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h3C;
    forever begin
      @(posedge clock);
      if (!reset && !bus.mem_nsel && bus.mem_nread && !bus.mem_nwrite)
        mem[bus.mem_address] = bus.mem_wdata;
    end
  end

  // Monitor: every selected bus cycle and every CPU read is checked against the queues.
  initial begin
    bus_op_t exp_op;
    logic    obs_we;
    logic [7:0] exp_rd;
    act_cycles = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.dma_active) act_cycles++;
        if (!bus.mem_nsel) begin
          obs_we = bus.mem_nread && !bus.mem_nwrite;
          if (cpu_q.size() > 0 && cpu_q[0].addr == bus.mem_address) begin
            exp_op = cpu_q.pop_front();
          end else if (dma_q.size() > 0) begin
            exp_op = dma_q.pop_front();
          end else begin
            exp_op = '{addr: 16'h0000, we: 1'b0, data: 8'h00};
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got bus cycle at %0h we=%0b, required none (t=%0t)",
                     bus.mem_address, obs_we, $time);
          end
          chk("bus_addr", 32'(bus.mem_address), 32'(exp_op.addr));
          chk("bus_we", 32'(obs_we), 32'(exp_op.we));
          if (exp_op.we) chk("bus_wdata", 32'(bus.mem_wdata), 32'(exp_op.data));
        end
        if (!bus.cpu_nsel && !bus.cpu_nread) begin
          if (rd_q.size() > 0) begin
            exp_rd = rd_q.pop_front();
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
          end else begin
            checks++;
            errors++;
            $display("FAIL cpu_rdata_unexpected: got read of %0h, required no read", bus.cpu_address);
          end
        end
      end
    end
  end

  task automatic cpu_release();
    bus.cpu_nsel   = 1'b1;
    bus.cpu_nread  = 1'b1;
    bus.cpu_nwrite = 1'b1;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic wr, input logic [7:0] d);
    bus.cpu_address = a;
    bus.cpu_wdata   = d;
    bus.cpu_nsel    = 1'b0;
    bus.cpu_nread   = wr;
    bus.cpu_nwrite  = !wr;
    @(posedge clock);
    #1;
    cpu_release();
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [7:0] exp, input logic pass);
    rd_q.push_back(exp);
    if (pass) cpu_q.push_back('{addr: a, we: 1'b0, data: 8'h00});
    cpu_cycle(a, 1'b0, 8'h00);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic pass);
    if (pass) cpu_q.push_back('{addr: a, we: 1'b1, data: d});
    cpu_cycle(a, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reference copy: 160 source reads each followed by its OAM write, in index order.
  task automatic push_dma(input logic [7:0] page);
    dma_q.delete();
    model_reg = page;
    for (int i = 0; i < 160; i++) begin
      logic [15:0] s;
      s = {page, 8'(i)};
      exp_src[i] = mem[s];
      dma_q.push_back('{addr: s, we: 1'b0, data: 8'h00});
      dma_q.push_back('{addr: 16'hFE00 + 16'(i), we: 1'b1, data: mem[s]});
    end
  endtask

  task automatic start_dma(input logic [7:0] page);
    cpu_wr(16'hFF46, page, 1'b0);
    push_dma(page);
    base_cycles = act_cycles;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (bus.dma_active && n < bound) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("dma_done", 32'(bus.dma_active), 32'd0);
  endtask

  task automatic wait_bus(input logic [15:0] a, input logic wr, input int bound);
    int n;
    n = 0;
    while (!(!bus.mem_nsel && bus.mem_address == a && (wr ? !bus.mem_nwrite : !bus.mem_nread))
           && n < bound) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("wait_bus_timeout", 32'(n < bound), 32'd1);
  endtask

  task automatic check_oam(input int upto);
    for (int i = 0; i < upto; i++)
      chk("oam_byte", 32'(mem[16'hFE00 + 16'(i)]), 32'(exp_src[i]));
  endtask

  initial begin
    logic [7:0]  saved;
    logic [7:0]  page;
    logic [15:0] a;
    int          hram;
    int          guard;
    checks = 0;
    errors = 0;
    model_reg = 8'hFF;
    reset = 1'b1;
    bus.cpu_address = 16'h0000;
    bus.cpu_wdata   = 8'h00;
    cpu_release();
    #1;
    chk("reset_dma_active", 32'(bus.dma_active), 32'd0);
    chk("reset_dma_reg", 32'(bus.dma_reg), 32'hFF);
    chk("reset_mem_nsel", 32'(bus.mem_nsel), 32'd1);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Idle passthrough and register reads.
    cpu_rd(16'h1234, mem[16'h1234], 1'b1);
    cpu_wr(16'hC000, 8'h5A, 1'b1);
    chk("idle_write_landed", 32'(mem[16'hC000]), 32'h5A);
    cpu_wr(16'hC000, 8'h3C, 1'b1);
    cpu_rd(16'hFF46, 8'hFF, 1'b0);
    idle(2);

    // Full DMA from page C0.
    start_dma(8'hC0);
    wait_idle(400);
    chk("full_cycles", 32'(act_cycles - base_cycles), 32'd321);
    check_oam(160);
    chk("full_dma_reg", 32'(bus.dma_reg), 32'hC0);
    cpu_rd(16'hFF46, 8'hC0, 1'b0);
    idle(2);

    // HRAM pause of 3 cycles at idx 50.
    start_dma(8'h40);
    wait_bus(16'h4032, 1'b0, 200);
    repeat (3) cpu_rd(16'hFF90, mem[16'hFF90], 1'b1);
    wait_idle(400);
    chk("hram_cycles", 32'(act_cycles - base_cycles), 32'd324);
    check_oam(160);
    idle(2);

    // Blocked CPU accesses during DMA.
    saved = mem[16'hD000];
    start_dma(8'h41);
    wait_bus(16'h4114, 1'b0, 200);
    cpu_rd(16'h8000, 8'hFF, 1'b0);
    cpu_wr(16'hD000, ~saved, 1'b0);
    cpu_rd(16'hFF46, 8'h41, 1'b0);
    wait_idle(400);
    chk("blocked_cycles", 32'(act_cycles - base_cycles), 32'd321);
    chk("blocked_write_dropped", 32'(mem[16'hD000]), 32'(saved));
    check_oam(160);
    idle(2);

    // Restart at WRITE idx 80 with page D0.
    start_dma(8'hC0);
    wait_bus(16'hFE50, 1'b1, 400);
    cpu_wr(16'hFF46, 8'hD0, 1'b0);
    push_dma(8'hD0);
    base_cycles = act_cycles;
    wait_idle(400);
    chk("restart_cycles", 32'(act_cycles - base_cycles), 32'd321);
    check_oam(160);
    idle(2);

    // Randomized traffic during transfers from random pages.
    for (int t = 0; t < 4; t++) begin
      page = 8'($urandom_range(0, 8'hDF));
      start_dma(page);
      idle(1);
      hram = 0;
      guard = 0;
      while (bus.dma_active && guard < 2000) begin
        guard++;
        case ($urandom_range(0, 7))
          0: begin
            a = 16'($urandom_range(16'hFF80, 16'hFFFE));
            cpu_rd(a, mem[a], 1'b1);
            hram++;
          end
          1: begin
            a = 16'($urandom_range(16'hFF80, 16'hFFFE));
            cpu_wr(a, 8'($urandom), 1'b1);
            hram++;
          end
          2: cpu_rd(16'($urandom_range(16'h8000, 16'hBFFF)), 8'hFF, 1'b0);
          3: cpu_wr(16'($urandom_range(16'hA000, 16'hBFFF)), 8'($urandom), 1'b0);
          4: cpu_rd(16'hFF46, model_reg, 1'b0);
          default: idle(1);
        endcase
      end
      chk("rand_done", 32'(bus.dma_active), 32'd0);
      chk("rand_cycles", 32'(act_cycles - base_cycles), 32'(321 + hram));
      check_oam(160);
      idle(2);
    end

    // Asynchronous reset in the middle of WRITE idx 10.
    saved = mem[16'hFE0A];
    start_dma(8'hC0);
    wait_bus(16'hFE0A, 1'b1, 200);
    bus.cpu_address = 16'h4321;
    bus.cpu_nsel    = 1'b0;
    bus.cpu_nread   = 1'b0;
    #2;
    reset = 1'b1;
    dma_q.delete();
    model_reg = 8'hFF;
    #1;
    chk("areset_dma_active", 32'(bus.dma_active), 32'd0);
    chk("areset_dma_reg", 32'(bus.dma_reg), 32'hFF);
    chk("areset_pass_nsel", 32'(bus.mem_nsel), 32'd0);
    chk("areset_pass_nread", 32'(bus.mem_nread), 32'd0);
    chk("areset_pass_addr", 32'(bus.mem_address), 32'h4321);
    chk("areset_pass_rdata", 32'(bus.cpu_rdata), 32'(mem[16'h4321]));
    cpu_release();
    idle(2);
    reset = 1'b0;
    idle(5);
    cpu_rd(16'hFF46, 8'hFF, 1'b0);
    check_oam(10);
    chk("areset_oam_untouched", 32'(mem[16'hFE0A]), 32'(saved));
    idle(2);

    chk("dma_q_empty", 32'(dma_q.size()), 32'd0);
    chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
